mac_seq_accumulator: RTL and testbench
======================================

# mac_seq_accumulator

Sequential unsigned multiply-accumulate stage for the MAC unit. It accepts operand pairs over a valid/ready handshake and forms each product with a W-cycle shift-add multiplier. The per-cycle additions are built from the full-adder ripple chain. Each product is added into a wide accumulator that has sticky overflow detection. The block sits downstream of the operand source and drives the MAC result register interface.

## Interface
- WIDTH, 8: operand width in bits.
- ACC_WIDTH, 20: accumulator width in bits. Must be >= 2*WIDTH; elaboration error otherwise.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b/clear is valid.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- a  input  WIDTH  unsigned multiplicand.
- b  input  WIDTH  unsigned multiplier.
- clear  input  1  sampled with an accepted pair: accumulator restarts from this product, and overflow is cleared.
- acc_out  output  ACC_WIDTH  accumulator value; changes only at the ACC edge.
- out_valid  output  1  one-cycle pulse: acc_out has just been updated.
- busy  output  1  high in MUL or ACC.
- overflow  output  1  sticky: the accumulator has wrapped since the last clear or reset.

## Operation
- FSM states: IDLE, MUL, ACC.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready, latch mcand={zeros,a} (2*WIDTH bits), mplr=b, prod=0, clr_q=clear, cnt=0, and go to MUL.
- MUL, one step per edge, exactly WIDTH edges with no early termination:
  - If mplr[0], prod <= prod + mcand (2*WIDTH-bit add, no carry out possible).
  - mcand <= mcand<<1; mplr <= mplr>>1; cnt <= cnt+1.
  - After the WIDTH-th step, go to ACC.
- ACC, one edge:
  - If clr_q: acc <= zero-extended prod, and overflow <= 0.
  - Else: acc <= (acc + prod) mod 2^ACC_WIDTH; overflow <= overflow | carry_out(ACC_WIDTH).
  - out_valid <= 1; go to IDLE.
- out_valid is a registered pulse lasting exactly one cycle.
- acc_out holds its value between updates.
- in_valid outside IDLE is ignored: no latch, and no state or output change.
- Inputs a/b/clear are don't-care when not accepted.
- All arithmetic is unsigned.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, busy=0, out_valid=0, acc_out=0, overflow=0. Internal registers mcand, mplr, prod, cnt and clr_q are all 0.
- Reset asserted mid-MUL or mid-ACC aborts the operation immediately. No out_valid is produced, and acc_out is 0 after release.
- First accepting edge after rst_n deasserts is the first edge where rst_n is high.
- Acceptance at edge 0 → MUL on edges 1..WIDTH → ACC edge WIDTH+1 updates acc_out, sets out_valid=1 and returns to IDLE.
- Therefore out_valid is high during cycle WIDTH+1 → WIDTH+2. Latency is WIDTH+1 edges from acceptance.
- in_ready=1 again after edge WIDTH+1. The next pair can be accepted at edge WIDTH+2 while out_valid is high.
  - Throughput: one operation per WIDTH+2 cycles.
  - If a pair is accepted on the edge where out_valid drops, that pair's later ACC uses the updated acc.
- busy = (state != IDLE) = !in_ready.
- Overflow and clear in the same ACC: clear wins, and overflow=0.

## Test plan
- Reset, then a=3, b=5, clear=1 → out_valid pulses 9 edges after acceptance with acc_out=15, overflow=0. in_ready is low for exactly 9 cycles.
- Follow-up a=255, b=255, clear=0 → acc_out=65040. Then a=2, b=2, clear=1 → acc_out=4.
- Overflow: a=255, b=255 with clear=1, then 16 more with clear=0 (17 total):
  - After the 16th: acc_out=1040400, overflow=0.
  - After the 17th: acc_out=56849, overflow=1.
  - Next op with clear=1 (1×1): acc_out=1, overflow=0.
- Backpressure: hold in_valid=1 with changing a/b during MUL → no extra acceptance and exactly one out_valid. Result matches the operands latched at acceptance.
- Reset mid-operation: drop rst_n asynchronously at MUL step 4 → outputs go to reset values immediately with no out_valid. Then 7×9 with clear=0 → acc_out=63.
- Zero operand: a=0, b=200, clear=1 → acc_out=0, with out_valid still pulsing at latency 9. Back-to-back accept at the edge after ACC is honoured.

Source files
------------

// File: rtl/mac_seq_accumulator.sv
// mac_seq_accumulator: sequential shift-add multiply with wrapping accumulator and sticky overflow
module mac_ripple_add #(
  parameter int N = 20
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);
  logic [N:0] w_c;
  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign o_sum[i]  = i_x[i] ^ i_y[i] ^ w_c[i];
    assign w_c[i+1]  = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
  end
  assign o_cout = w_c[N];
endmodule

module mac_seq_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overflow
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  if (ACC_WIDTH < PW) begin : g_bad_width
    $error("ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

  state_t               r_state, w_next;
  logic [PW-1:0]        r_mcand, r_prod;
  logic [WIDTH-1:0]     r_mplr;
  logic [CW-1:0]        r_cnt;
  logic                 r_clr_q, r_ovf, r_out_valid;
  logic [ACC_WIDTH-1:0] r_acc, w_add_x, w_add_y, w_sum;
  logic                 w_cout, w_accept, w_is_mul, w_is_acc;

  assign w_accept = r_state == S_IDLE && in_valid;
  assign w_is_mul = r_state == S_MUL;
  assign w_is_acc = r_state == S_ACC;

  // One shared ripple adder: partial-product add during MUL, accumulate during ACC
  assign w_add_x = w_is_acc ? r_acc : ACC_WIDTH'(r_prod);
  assign w_add_y = w_is_acc ? ACC_WIDTH'(r_prod) : (r_mplr[0] ? ACC_WIDTH'(r_mcand) : '0);

  mac_ripple_add #(.N(ACC_WIDTH)) u_add (
    .i_x    (w_add_x),
    .i_y    (w_add_y),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  // Next state: IDLE -> MUL on accept, MUL for WIDTH steps, ACC for one edge
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? S_MUL :
             w_is_mul ? (r_cnt == CW'(WIDTH - 1) ? S_ACC : S_MUL) :
             w_is_acc ? S_IDLE : r_state;
  end

  // Operand latch, shift-add steps and accumulator update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
      r_clr_q     <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_is_acc;
      if (w_accept) begin
        r_mcand <= PW'(a);
        r_mplr  <= b;
        r_prod  <= '0;
        r_clr_q <= clear;
        r_cnt   <= '0;
      end
      if (w_is_mul) begin
        r_prod  <= w_sum[PW-1:0];
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_is_acc) begin
        r_acc <= r_clr_q ? ACC_WIDTH'(r_prod) : w_sum;
        r_ovf <= !r_clr_q && (r_ovf || w_cout);
      end
    end

  assign in_ready  = r_state == S_IDLE;
  assign busy      = !in_ready;
  assign acc_out   = r_acc;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_mac_seq_accumulator.sv
// tb_mac_seq_accumulator: directed vector table plus multi-cycle corner sequences
module tb_mac_seq_accumulator;
  localparam int W  = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, busy, overflow;
  logic [AW-1:0] acc_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_seq_accumulator #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clear     (clear),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          clr;
    logic [AW-1:0] acc;
    logic          ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_c,
                        input bit hold, output logic [AW-1:0] r_acc, output logic r_ovf,
                        output int lat, output int low);
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    clear = op_c;
    @(posedge clk);
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
        clear = 1'($urandom);
      end else in_valid = 1'b0;
    end while (!out_valid && lat < 30);
    in_valid = 1'b0;
    r_acc = acc_out;
    r_ovf = overflow;
    lat = lat - 1;
  endtask

  task automatic vec(input string nm, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                     input logic op_c, input bit hold, input logic [AW-1:0] e_acc, input logic e_ovf);
    logic [AW-1:0] g_acc;
    logic          g_ovf;
    int            lat, low;
    run_op(op_a, op_b, op_c, hold, g_acc, g_ovf, lat, low);
    chk({nm, "_acc"}, 32'(g_acc), 32'(e_acc));
    chk({nm, "_ovf"}, 32'(g_ovf), 32'(e_ovf));
    chk({nm, "_latency"}, lat, 9);
    chk({nm, "_ready_low_cycles"}, low, 9);
  endtask

  initial begin
    longint tot;
    logic   e_ovf;
    int     extra;
    tbl[0] = '{8'd3,   8'd5,   1'b1, 20'd15,    1'b0};
    tbl[1] = '{8'd255, 8'd255, 1'b0, 20'd65040, 1'b0};
    tbl[2] = '{8'd2,   8'd2,   1'b1, 20'd4,     1'b0};
    tbl[3] = '{8'd0,   8'd200, 1'b1, 20'd0,     1'b0};
    tbl[4] = '{8'd6,   8'd6,   1'b0, 20'd36,    1'b0};
    tbl[5] = '{8'd200, 8'd0,   1'b0, 20'd36,    1'b0};

    #1 rst_n = 1'b0;
    #11;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) vec($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].clr, 1'b0, tbl[i].acc, tbl[i].ovf);
    @(negedge clk);
    chk("pulse_one_cycle", out_valid, 0);

    tot = 0;
    e_ovf = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tot = tot + 65025;
      if (tot >= (64'd1 << AW)) e_ovf = 1'b1;
      vec($sformatf("ovf%0d", k), 8'd255, 8'd255, k == 1, 1'b0, AW'(tot), e_ovf);
      if (k == 16) begin
        chk("ovf16_acc_hand", 32'(acc_out), 1040400);
        chk("ovf16_flag_hand", overflow, 0);
      end
      if (k == 17) begin
        chk("ovf17_acc_hand", 32'(acc_out), 56849);
        chk("ovf17_flag_hand", overflow, 1);
      end
    end

    in_valid = 1'b1;
    a = 8'd100;
    b = 8'd100;
    clear = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc", 32'(acc_out), 0);
    chk("mid_rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready || acc_out != '0) extra++;
    end
    chk("after_rst_quiet", extra, 0);
    vec("post_rst_7x9", 8'd7, 8'd9, 1'b0, 1'b0, 20'd63, 1'b0);
    vec("clear_1x1", 8'd1, 8'd1, 1'b1, 1'b0, 20'd1, 1'b0);

    vec("backpressure", 8'd13, 8'd11, 1'b1, 1'b1, 20'd143, 1'b0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready) extra++;
    end
    chk("bp_no_extra_accept", extra, 0);
    chk("bp_acc_held", 32'(acc_out), 143);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
